tinyalu_core: RTL

- Synthesizable TinyALU datapath that accepts one 8-bit operand pair plus an opcode per start/done handshake.
- Produces a 16-bit result with a one-cycle `done` pulse.
- Sits directly upstream of the result-monitoring stage, which samples `result` on every rising `clk` where `done` is high.
- Single-cycle logic ops and a 3-cycle pipelined multiply share one controller FSM.

---
 rtl/tinyalu_pkg.sv | 46 ++++
 rtl/tinyalu_mult_pipe.sv | 39 +++
 rtl/tinyalu_core.sv | 100 ++++++++++
 3 files changed

// File: rtl/tinyalu_pkg.sv
// TinyALU shared types: opcodes, controller states, default multiply latency.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tinyalu_pkg;

  localparam int MUL_LAT_DEFAULT = 3;

  typedef enum logic [2:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4
  } operation_t;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    MUL,
    DONE
  } alu_state_t;

  // Reserved encodings 5-7 collapse onto no_op so they never start a command.
  function automatic operation_t decode_op(input logic [2:0] raw);
    case (raw)
      3'd1:    return add_op;
      3'd2:    return and_op;
      3'd3:    return xor_op;
      3'd4:    return mul_op;
      default: return no_op;
    endcase
  endfunction

  // Single-cycle ops; the add keeps its carry in bit 8.
  function automatic logic [15:0] logic_result(input operation_t o,
                                               input logic [7:0] a,
                                               input logic [7:0] b);
    case (o)
      add_op:  return {7'b0, {1'b0, a} + {1'b0, b}};
      and_op:  return {8'b0, a & b};
      xor_op:  return {8'b0, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/tinyalu_mult_pipe.sv
// Registered 8x8 unsigned multiplier: operand stage plus MUL_LAT-1 product stages.
// Latency: product valid at output MUL_LAT-1 edges after the load edge.
// Backpressure: none; free-running shift, operands only reload on load_en.
module tinyalu_mult_pipe
  import tinyalu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product
);

  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] prod_q [MUL_LAT-1];

  // Hold operands from the capture edge, then push the product down the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < MUL_LAT - 1; i++) prod_q[i] <= '0;
    end else begin
      if (load_en) begin
        a_q <= a;
        b_q <= b;
      end
      prod_q[0] <= {8'b0, a_q} * {8'b0, b_q};
      for (int i = 1; i < MUL_LAT - 1; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  assign product = prod_q[MUL_LAT-2];

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU controller: captures one operand pair per start/done handshake, 16-bit result.
// Latency: add/and/xor done 1 edge after capture, mul done MUL_LAT edges after capture.
// Backpressure: start is held by the driver; ignored while busy and on the DONE edge.
module tinyalu_core
  import tinyalu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);

  localparam int CW = $clog2(MUL_LAT);

  alu_state_t     state;
  operation_t     op_dec;
  operation_t     op_q;
  logic [7:0]     a_q;
  logic [7:0]     b_q;
  logic [CW-1:0]  cnt;
  logic           mul_load;
  logic [15:0]    mul_product;

  assign op_dec   = decode_op(op);
  assign mul_load = (state == IDLE) && start && (op_dec == mul_op);

  tinyalu_mult_pipe #(
    .MUL_LAT (MUL_LAT)
  ) u_mult (
    .clk     (clk),
    .rst     (reset),
    .load_en (mul_load),
    .a       (A),
    .b       (B),
    .product (mul_product)
  );

  // Controller: capture, wait for the op to finish, pulse done once, then idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= no_op;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op_dec)
              add_op, and_op, xor_op: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op_dec;
                state <= SINGLE;
              end
              mul_op: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= mul_op;
                cnt   <= CW'(MUL_LAT - 1);
                state <= MUL;
              end
              default: ;
            endcase
          end
        end
        SINGLE: begin
          result <= logic_result(op_q, a_q, b_q);
          done   <= 1'b1;
          state  <= DONE;
        end
        MUL: begin
          if (cnt == '0) begin
            result <= mul_product;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          // start is deliberately not looked at here; next capture is one edge later.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
